// File: rtl/irq12_pkg.sv
// Shared definitions for the 24-line interrupt controller feeding the 12-bit processor:
// register addresses, FSM encoding and sizing defaults.
package irq12_pkg;

  localparam int NUM_IRQ_DEFAULT = 24;
  localparam int DATA_W_DEFAULT  = 12;
  localparam int VEC_W           = 5;

  localparam logic [1:0] IRQ_MASK_L = 2'd0;
  localparam logic [1:0] IRQ_MASK_H = 2'd1;
  localparam logic [1:0] IRQ_PEND_L = 2'd2;
  localparam logic [1:0] IRQ_PEND_H = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc12.sv
// Combinational priority encoder: the lowest set index wins; vld_o flags any request.
module irq_prio_enc12
  import irq12_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic [VEC_W-1:0]   idx_o,
  output logic               vld_o
);

  // Scanning from the top down lets the lowest set index overwrite last.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = VEC_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller12.sv
// Edge-detecting, maskable, non-nesting interrupt controller with a 4-register
// 12-bit bus view (mask and pending, each split into low/high halves).
module irq_controller12
  import irq12_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               bus_sel,
  input  logic               bus_we,
  input  logic [1:0]         bus_addr,
  input  logic [DATA_W-1:0]  bus_wdata,
  output logic [DATA_W-1:0]  bus_rdata,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vector,
  input  logic               irq_ack,
  input  logic               irq_eoi
);

  localparam int REG_W = 2 * DATA_W;

  irq_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] prev_q;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [REG_W-1:0]   mask_pad, pend_pad;
  logic [REG_W-1:0]   wmask_pad, wclr_pad;
  logic [NUM_IRQ-1:0] rise, ack_clr, enabled;
  logic [DATA_W-1:0]  rd_val;
  logic               ack_take;
  logic [VEC_W-1:0]   enc_idx;
  logic               enc_vld;

  // Registers are viewed zero-extended to two bus words so unimplemented bits read 0.
  assign mask_pad = REG_W'(mask_q);
  assign pend_pad = REG_W'(pend_q);

  always_comb begin
    wmask_pad = mask_pad;
    wclr_pad  = '0;
    if (bus_sel && bus_we) begin
      case (bus_addr)
        IRQ_MASK_L: wmask_pad[DATA_W-1:0]     = bus_wdata;
        IRQ_MASK_H: wmask_pad[REG_W-1:DATA_W] = bus_wdata;
        IRQ_PEND_L: wclr_pad[DATA_W-1:0]      = bus_wdata;
        default:    wclr_pad[REG_W-1:DATA_W]  = bus_wdata;
      endcase
    end
  end

  always_comb begin
    case (bus_addr)
      IRQ_MASK_L: rd_val = mask_pad[DATA_W-1:0];
      IRQ_MASK_H: rd_val = mask_pad[REG_W-1:DATA_W];
      IRQ_PEND_L: rd_val = pend_pad[DATA_W-1:0];
      default:    rd_val = pend_pad[REG_W-1:DATA_W];
    endcase
  end

  assign rdata_d = (bus_sel && !bus_we) ? rd_val : rdata_q;

  // A fresh rising edge always wins over the ack clear and the W1C clear.
  assign rise     = irq_src & ~prev_q;
  assign ack_take = (state_q == ST_REQ) && irq_ack;
  assign ack_clr  = ack_take ? (NUM_IRQ'(1) << vec_q) : '0;
  assign mask_d   = wmask_pad[NUM_IRQ-1:0];
  assign pend_d   = (pend_q & ~(wclr_pad[NUM_IRQ-1:0] | ack_clr)) | rise;
  assign enabled  = pend_q & mask_q;

  irq_prio_enc12 #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .req_i (enabled),
    .idx_o (enc_idx),
    .vld_o (enc_vld)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_vld) begin
          state_d = ST_REQ;
          vec_d   = enc_idx;
        end
      end
      ST_REQ: begin
        // The latched vector is never replaced; a cleared pending or mask bit withdraws it.
        if (irq_ack) begin
          state_d = ST_SERVICE;
        end else if (!pend_d[vec_q] || !mask_d[vec_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (irq_eoi) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      vec_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      prev_q  <= irq_src;
      vec_q   <= vec_d;
      rdata_q <= rdata_d;
    end
  end

  assign irq_req    = (state_q == ST_REQ);
  assign irq_vector = vec_q;
  assign bus_rdata  = rdata_q;

endmodule

// File: tb/tb_irq_controller12.sv
// Bench for irq_controller12: reset, table-driven flow, hand-written corner
// sequences and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_irq_controller12;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] irq_src;
  logic        bus_sel, bus_we;
  logic [1:0]  bus_addr;
  logic [11:0] bus_wdata;
  logic [11:0] bus_rdata;
  logic        irq_req;
  logic [4:0]  irq_vector;
  logic        irq_ack, irq_eoi;

  always #5 clk = ~clk;

  irq_controller12 #(.NUM_IRQ(24), .DATA_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .bus_sel    (bus_sel),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .irq_req    (irq_req),
    .irq_vector (irq_vector),
    .irq_ack    (irq_ack),
    .irq_eoi    (irq_eoi)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural reference state
  logic [23:0] m_mask, m_pend, m_prev;
  bit          m_req, m_svc;
  logic [4:0]  m_vec;
  logic [11:0] m_rdata;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] reg_val(input logic [1:0] a);
    case (a)
      2'd0:    return m_mask[11:0];
      2'd1:    return m_mask[23:12];
      2'd2:    return m_pend[11:0];
      default: return m_pend[23:12];
    endcase
  endfunction

  task automatic model_update();
    logic [23:0] rise, nmask, clr, npend, en;
    bit acked;
    if (!rst) begin
      m_mask = '0; m_pend = '0; m_prev = '0;
      m_req = 1'b0; m_svc = 1'b0; m_vec = '0; m_rdata = '0;
    end else begin
      rise  = irq_src & ~m_prev;
      nmask = m_mask;
      clr   = '0;
      if (bus_sel && !bus_we) m_rdata = reg_val(bus_addr);
      if (bus_sel && bus_we) begin
        case (bus_addr)
          2'd0:    nmask[11:0]  = bus_wdata;
          2'd1:    nmask[23:12] = bus_wdata;
          2'd2:    clr[11:0]    = bus_wdata;
          default: clr[23:12]   = bus_wdata;
        endcase
      end
      acked = m_req && irq_ack;
      if (acked) clr[m_vec] = 1'b1;
      npend = (m_pend & ~clr) | rise;
      en    = m_pend & m_mask;
      if (m_req) begin
        if (acked) begin
          m_req = 1'b0;
          m_svc = 1'b1;
        end else if (!npend[m_vec] || !nmask[m_vec]) begin
          m_req = 1'b0;
        end
      end else if (m_svc) begin
        if (irq_eoi) m_svc = 1'b0;
      end else if (en != 24'h0) begin
        for (int i = 0; i < 24; i++) begin
          if (en[i]) begin
            m_vec = 5'(i);
            break;
          end
        end
        m_req = 1'b1;
      end
      m_mask = nmask;
      m_pend = npend;
      m_prev = irq_src;
    end
  endtask

  // One clock: compare outputs with the model mid-cycle, advance the model, cross the edge.
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      check("model_req", {31'b0, irq_req}, {31'b0, m_req});
      check("model_vector", {27'b0, irq_vector}, {27'b0, m_vec});
      check("model_rdata", {20'b0, bus_rdata}, {20'b0, m_rdata});
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 2'd0; bus_wdata = 12'h0;
    irq_ack = 1'b0; irq_eoi = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [11:0] d);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    step();
    idle_inputs();
  endtask

  task automatic rd(input logic [1:0] a);
    bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
    step();
    idle_inputs();
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    irq_eoi = 1'b1; step(); irq_eoi = 1'b0;
  endtask

  typedef struct {
    logic        sel, we;
    logic [1:0]  addr;
    logic [11:0] wdata;
    logic [23:0] src;
    logic        ack, eoi;
    logic        exp_req;
    logic [4:0]  exp_vec;
    logic [11:0] exp_rdata;
  } row_t;

  row_t tbl [18];

  initial begin
    // sel we addr wdata src ack eoi | req vec rdata (outputs just after the edge)
    tbl[0]  = '{1'b1, 1'b1, 2'd0, 12'h010, 24'h0,       1'b0, 1'b0, 1'b0, 5'd0,  12'h000};
    tbl[1]  = '{1'b0, 1'b0, 2'd0, 12'h000, 24'h000010,  1'b0, 1'b0, 1'b0, 5'd0,  12'h000};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 12'h000, 24'h0,       1'b0, 1'b0, 1'b1, 5'd4,  12'h000};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 12'h000, 24'h0,       1'b0, 1'b0, 1'b1, 5'd4,  12'h000};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 12'h000, 24'h0,       1'b1, 1'b0, 1'b0, 5'd4,  12'h000};
    tbl[5]  = '{1'b1, 1'b0, 2'd2, 12'h000, 24'h0,       1'b0, 1'b0, 1'b0, 5'd4,  12'h000};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 12'h000, 24'h0,       1'b0, 1'b0, 1'b0, 5'd4,  12'h010};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 12'h000, 24'h0,       1'b0, 1'b1, 1'b0, 5'd4,  12'h010};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 12'h000, 24'h0,       1'b0, 1'b0, 1'b0, 5'd4,  12'h010};
    tbl[9]  = '{1'b1, 1'b1, 2'd0, 12'h000, 24'h0,       1'b0, 1'b0, 1'b0, 5'd4,  12'h010};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 12'h000, 24'h008000,  1'b0, 1'b0, 1'b0, 5'd4,  12'h010};
    tbl[11] = '{1'b1, 1'b0, 2'd3, 12'h000, 24'h008000,  1'b0, 1'b0, 1'b0, 5'd4,  12'h008};
    tbl[12] = '{1'b1, 1'b1, 2'd1, 12'h008, 24'h0,       1'b0, 1'b0, 1'b0, 5'd4,  12'h008};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 12'h000, 24'h0,       1'b0, 1'b0, 1'b1, 5'd15, 12'h008};
    tbl[14] = '{1'b1, 1'b0, 2'd1, 12'h000, 24'h0,       1'b0, 1'b0, 1'b1, 5'd15, 12'h008};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 12'h000, 24'h0,       1'b1, 1'b0, 1'b0, 5'd15, 12'h008};
    tbl[16] = '{1'b0, 1'b0, 2'd0, 12'h000, 24'h0,       1'b0, 1'b1, 1'b0, 5'd15, 12'h008};
    tbl[17] = '{1'b1, 1'b0, 2'd3, 12'h000, 24'h0,       1'b0, 1'b0, 1'b0, 5'd15, 12'h000};

    rst = 1'b0; irq_src = '0; idle_inputs();
    step();
    chk_en = 1'b1;

    // Reset held with lines toggling
    for (int i = 0; i < 3; i++) begin
      irq_src = (i % 2 == 1) ? 24'h0 : 24'hFFFFFF;
      step();
    end
    check("rst_req", {31'b0, irq_req}, 32'd0);
    check("rst_rdata", {20'b0, bus_rdata}, 32'd0);
    check("rst_vector", {27'b0, irq_vector}, 32'd0);
    irq_src = '0; rst = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      check($sformatf("rst_read[%0d]", a), {20'b0, bus_rdata}, 32'd0);
    end

    // Table-driven basic flow and masked-pending flow
    for (int r = 0; r < 18; r++) begin
      bus_sel = tbl[r].sel; bus_we = tbl[r].we; bus_addr = tbl[r].addr;
      bus_wdata = tbl[r].wdata; irq_src = tbl[r].src;
      irq_ack = tbl[r].ack; irq_eoi = tbl[r].eoi;
      step();
      check($sformatf("tbl_req[%0d]", r), {31'b0, irq_req}, {31'b0, tbl[r].exp_req});
      check($sformatf("tbl_vec[%0d]", r), {27'b0, irq_vector}, {27'b0, tbl[r].exp_vec});
      check($sformatf("tbl_rdata[%0d]", r), {20'b0, bus_rdata}, {20'b0, tbl[r].exp_rdata});
    end
    idle_inputs(); irq_src = '0;

    // Priority and non-preemption
    wr(2'd0, 12'hFFF);
    wr(2'd1, 12'hFFF);
    irq_src[20] = 1'b1; step();
    irq_src = '0; step();
    step();
    irq_src[3] = 1'b1; step();
    irq_src = '0; step(); step();
    check("prio_hold_req", {31'b0, irq_req}, 32'd1);
    check("prio_hold_vec", {27'b0, irq_vector}, 32'd20);
    pulse_ack();
    check("prio_ack_req", {31'b0, irq_req}, 32'd0);
    pulse_eoi();
    step();
    check("prio_next_req", {31'b0, irq_req}, 32'd1);
    check("prio_next_vec", {27'b0, irq_vector}, 32'd3);
    pulse_ack(); pulse_eoi(); step();

    // Withdrawal by W1C
    irq_src[7] = 1'b1; step();
    irq_src = '0; step();
    check("wd_req_vec", {27'b0, irq_vector}, 32'd7);
    wr(2'd2, 12'h080);
    check("wd_req_gone", {31'b0, irq_req}, 32'd0);
    step();
    check("wd_stay_idle", {31'b0, irq_req}, 32'd0);
    rd(2'd2);
    check("wd_pend", {20'b0, bus_rdata}, 32'd0);

    // Ack colliding with a new rise on the same line
    irq_src[7] = 1'b1; step();
    irq_src = '0; step();
    irq_ack = 1'b1; irq_src[7] = 1'b1; step();
    irq_ack = 1'b0; irq_src = '0;
    check("col_ack_req", {31'b0, irq_req}, 32'd0);
    rd(2'd2);
    check("col_pend", {20'b0, bus_rdata}, 32'h080);
    pulse_eoi();
    step();
    check("col_rereq", {31'b0, irq_req}, 32'd1);
    check("col_vec", {27'b0, irq_vector}, 32'd7);
    pulse_ack(); pulse_eoi(); step();

    // Reset during service
    irq_src[9] = 1'b1; step();
    irq_src = '0; step();
    pulse_ack();
    check("rs_svc_vec", {27'b0, irq_vector}, 32'd9);
    rst = 1'b0; step(); step();
    check("rs_req", {31'b0, irq_req}, 32'd0);
    check("rs_vec", {27'b0, irq_vector}, 32'd0);
    check("rs_rdata", {20'b0, bus_rdata}, 32'd0);
    rst = 1'b1;
    wr(2'd0, 12'h200);
    irq_src[9] = 1'b1; step();
    irq_src = '0; step();
    check("rs_after_req", {31'b0, irq_req}, 32'd1);
    check("rs_after_vec", {27'b0, irq_vector}, 32'd9);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 149) != 0);
      irq_src   = irq_src ^ (24'($urandom) & 24'($urandom) & 24'($urandom));
      bus_sel   = ($urandom_range(0, 3) == 0);
      bus_we    = ($urandom_range(0, 1) == 1);
      bus_addr  = 2'($urandom);
      bus_wdata = 12'($urandom);
      irq_ack   = ($urandom_range(0, 2) == 0);
      irq_eoi   = ($urandom_range(0, 4) == 0);
      step();
    end
    rst = 1'b1; idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_controller12.md
Name: irq_controller12

Overview:
- Interrupt controller directly upstream of the 12-bit processor; produces the request and vector that feed the processor's interrupt input.
- Detects rising edges on 24 peripheral interrupt lines and latches them as pending.
- Applies a software-writable mask and presents the highest-priority enabled interrupt as a request/vector pair.
- Tracks one in-service interrupt until end-of-interrupt (non-nesting); exposes mask/pending registers on a 12-bit memory-mapped bus.

Parameters:
NUM_IRQ, 24, number of interrupt lines (fixed by 2x12-bit register split; implementation supports 13..24)
DATA_W, 12, bus data width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
irq_src  input  NUM_IRQ  peripheral interrupt lines, already synchronous to clk
bus_sel  input  1  register access strobe
bus_we  input  1  1 = write, 0 = read (qualified by bus_sel)
bus_addr  input  2  register select
bus_wdata  input  DATA_W  write data
bus_rdata  output  DATA_W  read data, registered
irq_req  output  1  interrupt request to processor
irq_vector  output  5  index of requested interrupt, 0..NUM_IRQ-1
irq_ack  input  1  processor accepts current vector (single-cycle pulse)
irq_eoi  input  1  processor signals end of service (single-cycle pulse)

Behaviour:
- Reset: synchronous, active-low, sampled on clk rising edge.
  - irq_req=0, irq_vector=0, bus_rdata=0.
  - mask=0 (all disabled), pending=0, irq_prev=0, state=IDLE.
  - Reset asserted mid-request or mid-service aborts immediately; no ack/eoi is required afterwards.
- Edge detect:
  - irq_prev <= irq_src every cycle.
  - rise = irq_src & ~irq_prev; pending |= rise.
  - Level-held lines raise exactly one pending event.
- Register map:
  - 0 = MASK_L (bits 11:0), R/W.
  - 1 = MASK_H (bits 23:12), R/W; unimplemented bits read 0.
  - 2 = PEND_L, read; write-1-to-clear.
  - 3 = PEND_H, read; write-1-to-clear.
- Bus timing:
  - Read: bus_sel & ~bus_we at cycle N -> bus_rdata holds the register value at cycle N+1 (pre-update value when other events occur in cycle N). bus_rdata holds its value otherwise.
  - Write takes effect at the end of the cycle it is presented.
- Priority: enabled = pending & mask; lowest index wins.
- FSM (3 states):
  - IDLE:
    - irq_req=0.
    - If enabled != 0: latch irq_vector = priority index; go REQ.
    - irq_ack and irq_eoi ignored.
  - REQ:
    - irq_req=1; irq_vector held stable. Higher-priority arrivals do not replace the latched vector.
    - irq_ack: clear pending[irq_vector]; go SERVICE.
    - pending[irq_vector] cleared by a bus write, or mask[irq_vector] cleared, without irq_ack: go IDLE (request withdrawn next cycle).
    - irq_ack has precedence over a simultaneous withdrawal.
  - SERVICE:
    - irq_req=0; irq_vector holds.
    - New edges continue to set pending.
    - irq_eoi: go IDLE.
    - irq_ack ignored.
- Simultaneous events on one pending bit, priority order:
  - new rising edge (bit ends set) > ack clear / bus W1C clear.
- Minimum spacing: back-to-back interrupts re-request no earlier than 1 cycle after eoi (IDLE evaluation cycle).
- Latency: edge at cycle N -> pending set N+1 -> REQ/irq_req=1 at N+2, provided state was IDLE and the bit is enabled.

Decomposition:
- Shared package irq12_pkg:
  - register address constants (IRQ_MASK_L=0, IRQ_MASK_H=1, IRQ_PEND_L=2, IRQ_PEND_H=3);
  - FSM state encoding (IDLE, REQ, SERVICE);
  - NUM_IRQ default.
- One sub-module: irq_prio_enc12, a combinational lowest-index-first priority encoder (NUM_IRQ in -> 5-bit index + valid).

Test Plan:
- Reset/defaults: hold rst=0 for 3 cycles with irq_src toggling -> irq_req=0, bus_rdata=0; reads of all four registers return 0x000.
- Basic flow:
  - Setup: write MASK_L=0x010; pulse irq_src[4] at cycle N.
  - Required: irq_req=1 at N+2 with irq_vector=4.
  - Ack -> irq_req=0, PEND_L reads 0x000.
  - eoi -> IDLE.
- Priority + non-preemption:
  - Setup: mask=0xFFFFFF; rise irq_src[20] at N; rise irq_src[3] at N+3 while in REQ.
  - Required: vector stays 20 until ack.
  - After eoi, the next request is vector 3.
- Masked pending:
  - Setup: mask=0; rise irq_src[15]; PEND_H reads 0x008.
  - Required: irq_req stays 0.
  - Write MASK_H=0x008 -> irq_req=1 two cycles later, vector=15.
- Withdrawal and collision:
  - In REQ on vector 7, write PEND_L=0x080 (W1C) -> irq_req=0 next cycle, state IDLE.
  - Separately, an irq_ack cycle that coincides with a new rise on the same line -> pending[7] remains 1 and re-requests after eoi.
- Reset mid-service: assert rst during SERVICE -> all outputs return to reset values; subsequent edge requests normally without eoi.
